// File: rtl/extras_bus_master_if.sv
// Bus between the game-side initiator and the extras peripheral (timer, strike LEDs).
// The master drives strobes, addresses and write data; the slave returns registered read data.
interface extras_bus_master_if;
   logic        en;
   logic        we;
   logic        re;
   logic [15:0] write_addr;
   logic [15:0] read_addr;
   logic [15:0] data;
   logic [15:0] q;

   modport master (
      output en, we, re, write_addr, read_addr, data,
      input  q
   );

   modport slave (
      input  en, we, re, write_addr, read_addr, data,
      output q
   );
endinterface

// File: rtl/extras_bus_master.sv
// Extras bus initiator: turns start/strike/clear events into single-cycle bus writes,
// polls the timer's seconds-left register, and tracks strikes and the exploded flag.
module extras_bus_master #(
   parameter logic [15:0] TIMER_ADDR  = 16'hF330,
   parameter logic [15:0] STRIKE_ADDR = 16'hF663,
   parameter int          POLL_CYCLES = 1000,
   parameter int          MAX_STRIKES = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [15:0]         start_secs,
   input  logic                strike,
   input  logic                clear,
   extras_bus_master_if.master bus,
   output logic [15:0]         secs_left,
   output logic [1:0]          strikes,
   output logic                exploded,
   output logic                busy
);

   localparam int               CNT_W        = $clog2(POLL_CYCLES);
   localparam logic [CNT_W-1:0] POLL_LAST    = CNT_W'(POLL_CYCLES - 1);
   localparam logic [1:0]       STRIKE_LIMIT = 2'(MAX_STRIKES);

   typedef enum logic [2:0] {IDLE, WR, WR_HOLD, RD, RD_WAIT} stateT;

   stateT            state;
   logic             pendStart;
   logic             pendClear;
   logic             pendStrike;
   logic [15:0]      startSecsReg;
   logic [CNT_W-1:0] pollCnt;
   logic             pollDue;
   logic             armed;
   logic             secondWrite;
   logic             enReg;
   logic             weReg;
   logic             reReg;
   logic [15:0]      writeAddrReg;
   logic [15:0]      readAddrReg;
   logic [15:0]      dataReg;

   logic             takeStart;
   logic             takeClear;
   logic             takeStrike;
   logic             takePoll;
   logic             pollWrap;
   logic [1:0]       strikeNext;

   assign bus.en         = enReg;
   assign bus.we         = weReg;
   assign bus.re         = reReg;
   assign bus.write_addr = writeAddrReg;
   assign bus.read_addr  = readAddrReg;
   assign bus.data       = dataReg;
   assign busy           = (state != IDLE);

   // Decide which pending job IDLE launches this cycle, and when the poll counter wraps.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      takeStart  = 1'b0;
      takeClear  = 1'b0;
      takeStrike = 1'b0;
      takePoll   = 1'b0;
      strikeNext = (strikes == 2'd3) ? 2'd3 : strikes + 2'd1;
      if (state == IDLE) begin
         if (pendStart)             takeStart  = 1'b1;
         else if (pendClear)        takeClear  = 1'b1;
         else if (pendStrike)       takeStrike = 1'b1;
         else if (pollDue && armed) takePoll   = 1'b1;
      end
      pollWrap = armed && !takeStart && (pollCnt == POLL_LAST);
   end

   // Latch incoming events; repeats merge, and a strike is dropped while a start is pending.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments, so every register here sees the pre-edge values.
      if (!rst_n) begin
         pendStart    <= 1'b0;
         pendClear    <= 1'b0;
         pendStrike   <= 1'b0;
         startSecsReg <= 16'd0;
      end else begin
         pendStart  <= start | (pendStart & ~takeStart);
         pendClear  <= clear | (pendClear & ~takeClear);
         pendStrike <= (strike & ~start & ~pendStart) | (pendStrike & ~takeStrike);
         if (start) startSecsReg <= start_secs;
      end
   end

   // Free-running poll timer; a due poll stays flagged until the read is launched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pollCnt <= '0;
         pollDue <= 1'b0;
      end else begin
         if (takeStart)     pollCnt <= '0;
         else if (pollWrap) pollCnt <= '0;
         else if (armed)    pollCnt <= pollCnt + 1'b1;
         pollDue <= (pollDue & ~takePoll) | pollWrap;
      end
   end

   // Bus sequencer with registered strobes, plus the strike/secs/exploded bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         enReg        <= 1'b0;
         weReg        <= 1'b0;
         reReg        <= 1'b0;
         writeAddrReg <= 16'd0;
         readAddrReg  <= 16'd0;
         dataReg      <= 16'd0;
         secs_left    <= 16'd0;
         strikes      <= 2'd0;
         exploded     <= 1'b0;
         armed        <= 1'b0;
         secondWrite  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (takeStart) begin
                  state        <= WR;
                  enReg        <= 1'b1;
                  weReg        <= 1'b1;
                  writeAddrReg <= TIMER_ADDR;
                  dataReg      <= startSecsReg;
                  strikes      <= 2'd0;
                  exploded     <= 1'b0;
                  armed        <= 1'b1;
                  secondWrite  <= 1'b1;
               end else if (takeClear) begin
                  state        <= WR;
                  enReg        <= 1'b1;
                  weReg        <= 1'b1;
                  writeAddrReg <= STRIKE_ADDR;
                  dataReg      <= 16'd0;
                  strikes      <= 2'd0;
               end else if (takeStrike) begin
                  state        <= WR;
                  enReg        <= 1'b1;
                  weReg        <= 1'b1;
                  writeAddrReg <= STRIKE_ADDR;
                  dataReg      <= {14'd0, strikeNext};
                  strikes      <= strikeNext;
                  if (strikeNext >= STRIKE_LIMIT) exploded <= 1'b1;
               end else if (takePoll) begin
                  state       <= RD;
                  enReg       <= 1'b1;
                  reReg       <= 1'b1;
                  readAddrReg <= TIMER_ADDR;
               end
            end
            WR: begin
               state <= WR_HOLD;
               weReg <= 1'b0;
            end
            WR_HOLD: begin
               if (secondWrite) begin
                  state        <= WR;
                  weReg        <= 1'b1;
                  writeAddrReg <= STRIKE_ADDR;
                  dataReg      <= 16'd0;
                  secondWrite  <= 1'b0;
               end else begin
                  state <= IDLE;
                  enReg <= 1'b0;
               end
            end
            RD: begin
               state <= RD_WAIT;
               reReg <= 1'b0;
            end
            RD_WAIT: begin
               state     <= IDLE;
               enReg     <= 1'b0;
               secs_left <= bus.q;
               if (armed && bus.q == 16'd0) exploded <= 1'b1;
            end
            default: begin
               state <= IDLE;
               enReg <= 1'b0;
               weReg <= 1'b0;
               reReg <= 1'b0;
            end
         endcase
      end
   end

endmodule
